// File: rtl/spi_host_seq_pkg.sv
// Shared definitions for the SPI host TX byte sequencer.
package spi_host_seq_pkg;

    localparam int unsigned LEN_W_DEFAULT     = 9;
    localparam logic [7:0]  FILL_BYTE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DUMMY = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spi_host_tx_sequencer.sv
// Sequences one command segment of TX or dummy bytes towards the shift engine,
// with an optional one-cycle flush of the upstream byte selector afterwards.
module spi_host_tx_sequencer
    import spi_host_seq_pkg::*;
#(
    parameter int unsigned LenW     = LEN_W_DEFAULT,
    parameter logic [7:0]  FillByte = FILL_BYTE_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sw_rst_i,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [LenW-1:0] cmd_len_i,
    input  logic            cmd_tx_en_i,
    input  logic            cmd_flush_i,

    input  logic [7:0]      byte_i,
    input  logic            byte_valid_i,
    output logic            byte_ready_o,
    output logic            flush_o,

    output logic [7:0]      out_byte_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_last_o,

    output logic            busy_o,
    output logic            done_o
);

    seq_state_e      state_q, state_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            done_q, done_d;
    logic            flush_q, flush_d;
    logic            cnt_zero;
    logic            xfer;

    assign cnt_zero = (cnt_q == '0);
    assign xfer     = out_valid_o & out_ready_i;
    assign flush_o  = flush_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != ST_IDLE);

    // Zero-latency byte path: pass-through in RUN, fill byte in DUMMY, quiet otherwise
    always_comb begin
        cmd_ready_o  = 1'b0;
        byte_ready_o = 1'b0;
        out_valid_o  = 1'b0;
        out_byte_o   = 8'h00;
        out_last_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = ~sw_rst_i;
            end
            ST_RUN: begin
                out_valid_o  = byte_valid_i;
                out_byte_o   = byte_i;
                byte_ready_o = out_ready_i;
                out_last_o   = cnt_zero;
            end
            ST_DUMMY: begin
                out_valid_o = 1'b1;
                out_byte_o  = FillByte;
                out_last_o  = cnt_zero;
            end
            default: ;
        endcase
    end

    // Next-state, byte counter and completion pulses
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    cnt_d        = cmd_len_i;
                    flush_pend_d = cmd_flush_i;
                    state_d      = cmd_tx_en_i ? ST_RUN : ST_DUMMY;
                end
            end
            ST_RUN, ST_DUMMY: begin
                if (xfer) begin
                    if (cnt_zero) begin
                        if (flush_pend_q) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - LenW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Software reset wins over any pending transfer or completion
        if (sw_rst_i) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
            done_d       = 1'b0;
        end
        flush_d = (state_d == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
            flush_q      <= flush_d;
        end
    end

endmodule

// File: tb/tb_spi_host_tx_sequencer.sv
// Self-checking bench: segment-level reference model (expected byte list per command,
// expected pulse timing) against randomized and directed stimulus.
module tb_spi_host_tx_sequencer;

    localparam int unsigned LEN_W = 9;
    localparam logic [7:0]  FILL  = 8'h00;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             sw_rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [LEN_W-1:0] cmd_len_i;
    logic             cmd_tx_en_i;
    logic             cmd_flush_i;
    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             byte_ready_o;
    logic             flush_o;
    logic [7:0]       out_byte_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;
    logic             busy_o;
    logic             done_o;

    int n_cmp = 0;
    int n_err = 0;

    spi_host_tx_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sw_rst_i     (sw_rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_len_i    (cmd_len_i),
        .cmd_tx_en_i  (cmd_tx_en_i),
        .cmd_flush_i  (cmd_flush_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .flush_o      (flush_o),
        .out_byte_o   (out_byte_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Everything except cmd_ready must be quiet (reset or idle)
    task automatic chk_quiet(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
        chk({tag, "_byte_ready"}, 32'(byte_ready_o), 0);
        chk({tag, "_out_byte"}, 32'(out_byte_o), 0);
        chk({tag, "_out_last"}, 32'(out_last_o), 0);
        chk({tag, "_flush"}, 32'(flush_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // One command segment. Entered and left 2 time units after a rising edge in an idle cycle.
    // mode: 0 always ready/valid, 1 random stalls, 2 out_ready toggles.
    // base >= 0 gives bytes base+i, else random. abort_at >= 0 aborts after that many
    // transfers: by sw_rst_i (hard=0) or by rst_i (hard=1).
    task automatic run_segment(input int len, input bit tx, input bit fl, input int mode,
                               input int base, input int abort_at, input bit hard);
        logic [7:0] src [$];
        int  sent   = 0;
        int  cyc    = 0;
        int  budget = 8 * (len + 1) + 20;
        bit  orr;
        bit  bv;
        bit  tog    = 1'b1;
        bit  xf;
        logic [7:0] exp_byte;
        src = {};
        for (int i = 0; i <= len; i++)
            src.push_back(base >= 0 ? 8'(base + i) : 8'($urandom));

        chk("cmd_ready_idle", 32'(cmd_ready_o), 1);
        chk("busy_idle", 32'(busy_o), 0);
        cmd_valid_i = 1'b1;
        cmd_len_i   = LEN_W'(len);
        cmd_tx_en_i = tx;
        cmd_flush_i = fl;
        @(posedge clk_i); #1;

        while (sent <= len && cyc < budget) begin
            unique case (mode)
                0:       begin orr = 1'b1; bv = 1'b1; end
                1:       begin orr = 1'($urandom % 2); bv = ($urandom % 4) != 0; end
                default: begin orr = tog; tog = ~tog; bv = 1'b1; end
            endcase
            out_ready_i  = orr;
            byte_valid_i = bv;
            byte_i       = src[sent];
            cmd_valid_i  = 1'($urandom % 2);
            cmd_len_i    = LEN_W'($urandom);
            cmd_tx_en_i  = 1'($urandom % 2);
            cmd_flush_i  = 1'($urandom % 2);

            if (abort_at == sent) begin
                cmd_valid_i = 1'b0;
                if (hard) begin
                    rst_i = 1'b1;
                    #1;
                    chk_quiet("async_rst");
                    @(posedge clk_i); #1;
                    chk_quiet("rst_held");
                    rst_i = 1'b0;
                    #1;
                    chk("cmd_ready_after_rst", 32'(cmd_ready_o), 1);
                end else begin
                    sw_rst_i = 1'b1;
                    #1;
                    chk("sw_rst_busy_during", 32'(busy_o), 1);
                    @(posedge clk_i); #1;
                    sw_rst_i = 1'b0;
                    #1;
                    chk_quiet("sw_rst_next");
                    chk("cmd_ready_after_sw_rst", 32'(cmd_ready_o), 1);
                end
                @(posedge clk_i); #2;
                chk_quiet("abort_idle");
                return;
            end

            #1;
            exp_byte = tx ? src[sent] : FILL;
            chk("out_valid", 32'(out_valid_o), tx ? 32'(bv) : 1);
            chk("byte_ready", 32'(byte_ready_o), tx ? 32'(orr) : 0);
            chk("out_byte", 32'(out_byte_o), 32'(exp_byte));
            chk("out_last", 32'(out_last_o), 32'(sent == len));
            chk("busy_run", 32'(busy_o), 1);
            chk("done_run", 32'(done_o), 0);
            chk("flush_run", 32'(flush_o), 0);
            chk("cmd_ready_run", 32'(cmd_ready_o), 0);
            xf = tx ? (bv & orr) : orr;
            if (xf) sent++;
            @(posedge clk_i); #1;
            cyc++;
        end
        cmd_valid_i = 1'b0;
        chk("seg_transfers", 32'(sent), 32'(len + 1));
        #1;
        if (fl) begin
            chk("flush_pulse", 32'(flush_o), 1);
            chk("flush_busy", 32'(busy_o), 1);
            chk("flush_done", 32'(done_o), 0);
            chk("flush_out_valid", 32'(out_valid_o), 0);
            @(posedge clk_i); #2;
        end
        chk("done_pulse", 32'(done_o), 1);
        chk("done_flush_low", 32'(flush_o), 0);
        chk("done_busy", 32'(busy_o), 0);
        chk("done_out_valid", 32'(out_valid_o), 0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #2;
            chk_quiet("gap");
            chk("gap_cmd_ready", 32'(cmd_ready_o), 1);
        end
    endtask

    initial begin
        rst_i        = 1'b0;
        sw_rst_i     = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_len_i    = '0;
        cmd_tx_en_i  = 1'b0;
        cmd_flush_i  = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        out_ready_i  = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        chk("cmd_ready_post_reset", 32'(cmd_ready_o), 1);
        chk_quiet("post_reset");

        // Directed scenarios
        run_segment(3, 1'b1, 1'b0, 0, 'hA0, -1, 1'b0);
        idle_gap(1);
        run_segment(1, 1'b0, 1'b0, 0, -1, -1, 1'b0);
        idle_gap(1);
        run_segment(0, 1'b1, 1'b1, 0, -1, -1, 1'b0);
        run_segment(4, 1'b1, 1'b0, 2, 'h10, -1, 1'b0);
        run_segment(5, 1'b1, 1'b0, 0, 'h50, 2, 1'b0);
        run_segment(5, 1'b1, 1'b1, 1, -1, -1, 1'b0);

        // Software reset held in idle blocks command acceptance
        sw_rst_i    = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_tx_en_i = 1'b1;
        #1;
        chk("cmd_ready_sw_rst_idle", 32'(cmd_ready_o), 0);
        @(posedge clk_i); #1;
        sw_rst_i    = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        chk("busy_after_blocked_cmd", 32'(busy_o), 0);

        run_segment(10, 1'b0, 1'b1, 0, -1, 3, 1'b1);
        run_segment(2, 1'b0, 1'b1, 1, -1, -1, 1'b0);

        // Randomized segments, mostly back-to-back
        for (int k = 0; k < 25; k++) begin
            run_segment(int'($urandom_range(0, 20)), 1'($urandom % 2), 1'($urandom % 2),
                        int'($urandom_range(0, 2)), -1, -1, 1'b0);
            if ($urandom % 3 == 0) idle_gap(int'($urandom_range(1, 2)));
        end

        // Full-length segment: 2^LenW bytes without counter wrap
        run_segment(511, 1'b1, 1'b1, 1, -1, -1, 1'b0);
        idle_gap(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_host_tx_sequencer.md
SPI_HOST_TX_SEQUENCER -- requirements
Module: spi_host_tx_sequencer

Interface
REQ-001 SHALL have parameter LenW, default 9, width of the command byte-count field.
REQ-002 SHALL have parameter FillByte, default 8'h00, value emitted for dummy (non-TX) bytes.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw_rst_i  input  1  synchronous software reset.
REQ-006 SHALL have ports cmd_valid_i input 1 / cmd_ready_o output 1  command handshake.
REQ-007 SHALL have port cmd_len_i  input  LenW  number of bytes minus one.
REQ-008 SHALL have port cmd_tx_en_i  input  1  1: bytes taken from byte stream; 0: FillByte emitted.
REQ-009 SHALL have port cmd_flush_i  input  1  discard residual word bytes after segment.
REQ-010 SHALL have ports byte_i input 8, byte_valid_i input 1, byte_ready_o output 1  upstream byte stream from byte selector.
REQ-011 SHALL have port flush_o  output  1  one-cycle flush pulse to byte selector.
REQ-012 SHALL have ports out_byte_o output 8, out_valid_o output 1, out_ready_i input 1, out_last_o output 1  byte stream to shift engine.
REQ-013 SHALL have ports busy_o output 1 (state not IDLE) and done_o output 1 (one-cycle segment-complete pulse).

Function
REQ-014 States: IDLE, RUN, DUMMY, FLUSH; LenW-bit down-counter cnt.
REQ-015 IDLE: cmd_ready_o = ~sw_rst_i; on cmd_valid_i & cmd_ready_o load cnt = cmd_len_i, latch cmd_flush_i; go RUN if cmd_tx_en_i else DUMMY.
REQ-016 RUN: out_valid_o = byte_valid_i, out_byte_o = byte_i, byte_ready_o = out_ready_i, all combinational, zero latency.
REQ-017 DUMMY: out_valid_o = 1, out_byte_o = FillByte, byte_ready_o = 0.
REQ-018 out_last_o = (cnt == 0) in RUN/DUMMY, else 0.
REQ-019 Transfer = out_valid_o & out_ready_i; on transfer with cnt != 0, cnt decrements; with cnt == 0, next state FLUSH if latched flush else IDLE.
REQ-020 FLUSH: flush_o = 1 for exactly one cycle, then IDLE; flush_o = 0 in all other states.
REQ-021 done_o registered: high the cycle after the final transfer when no flush, else the cycle after FLUSH.
REQ-022 Outside RUN/DUMMY: out_valid_o = 0, byte_ready_o = 0, out_byte_o = 0.
REQ-023 Back-to-back commands: a new command accepted in the first IDLE cycle; minimum one-cycle bubble between segments.
REQ-024 cmd_len_i = 0 yields exactly one byte with out_last_o high; cmd_len_i all-ones yields 2^LenW bytes, no wrap.
REQ-025 Stalls (out_ready_i low or byte_valid_i low) SHALL hold cnt and state indefinitely.
REQ-026 sw_rst_i high: next state IDLE, cnt = 0, done_o = 0, flush_o = 0, regardless of current state or pending transfer.

Reset
REQ-027 rst_i high SHALL asynchronously force state IDLE, cnt 0, latched flush 0, done_o 0.
REQ-028 During and after reset: cmd_ready_o = 1 (after rst_i deassert), all other outputs 0, busy_o 0.
REQ-029 Reset mid-segment SHALL drop the segment with no done_o and no flush_o pulse.

Structure
REQ-030 State enum and LenW/FillByte defaults SHALL live in shared package spi_host_seq_pkg.
REQ-031 No sub-module; FSM and counter implemented in one module.

Verification
REQ-032 cmd len=3, tx_en=1, flush=0, bytes A0..A3 always valid, out_ready=1 -> four bytes A0..A3 on consecutive cycles, last on A3, done_o next cycle, no flush_o.
REQ-033 cmd len=1, tx_en=0 -> two bytes 0x00, byte_ready_o never high, last on second.
REQ-034 cmd len=0, tx_en=1, flush=1 -> one byte, then flush_o one cycle, then done_o, then cmd_ready_o high.
REQ-035 len=4, out_ready_i toggled every other cycle -> exactly 5 transfers, order preserved, cnt held while stalled.
REQ-036 sw_rst_i pulsed after 2 of 6 bytes -> IDLE next cycle, no done_o, no flush_o, next command runs normally.
REQ-037 rst_i asserted mid-DUMMY -> all outputs 0 immediately (asynchronously), busy_o 0.
